// File: rtl/sdram_loader_pkg.sv
// sdram_loader_pkg: loader FSM states, header size and timeout counter sizing.
package sdram_loader_pkg;

    typedef enum logic [2:0] {HDR, DHI, DLO, REQ, WREL, FIN} state_t;

    localparam int HDR_BYTES = 8;

    function automatic int tmo_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/loader_hdr_parser.sv
// loader_hdr_parser: assembles the 8-byte big-endian {start address, length} frame header.
module loader_hdr_parser
    import sdram_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  data,
    output logic        first,
    output logic        last,
    output logic [31:0] addr,
    output logic [31:0] len
);

    logic [2:0]  cnt;
    logic [55:0] sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            sh  <= '0;
        end else if (en) begin
            cnt <= cnt + 3'd1;
            sh  <= {sh[47:0], data};
        end
    end

    // Fields are valid while the eighth byte is on data, so the top can load them in that cycle.
    assign first = en && cnt == '0;
    assign last  = en && cnt == 3'(HDR_BYTES - 1);
    assign addr  = sh[55:24];
    assign len   = {sh[23:0], data};

endmodule

// File: rtl/sdram_rom_loader.sv
// sdram_rom_loader: framed byte stream to big-endian halfword writes on the SDRAM write port.
module sdram_rom_loader
    import sdram_loader_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE    = 8'h00,
    parameter int         ACK_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        writeport_wr,
    output logic [31:0] writeport_addr,
    output logic [15:0] writeport_data,
    input  logic        writeport_ack,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int CW = tmo_w(ACK_TIMEOUT);

    state_t      state, state_nxt;
    logic [31:0] addr_r, len_r, hdr_addr, hdr_len;
    logic [15:0] data_r;
    logic [CW-1:0] cnt;
    logic        busy_r, error_r, take, tmo, hdr_first, hdr_last, abort;

    loader_hdr_parser u_hdr (
        .clk   (clk),
        .rst   (rst),
        .en    (take && state == HDR),
        .data  (in_data),
        .first (hdr_first),
        .last  (hdr_last),
        .addr  (hdr_addr),
        .len   (hdr_len)
    );

    always_comb begin
        in_ready     = rst && (state == HDR || state == DHI || state == DLO);
        take         = in_valid && in_ready;
        tmo          = cnt == CW'(ACK_TIMEOUT - 1);
        writeport_wr = state == REQ;
        done         = state == FIN;
        state_nxt    = state;
        case (state)
            HDR:     state_nxt = hdr_last ? (hdr_len == '0 ? FIN : DHI) : HDR;
            DHI:     state_nxt = take ? (len_r == 32'd1 ? REQ : DLO) : DHI;
            DLO:     state_nxt = take ? REQ : DLO;
            REQ:     state_nxt = writeport_ack ? WREL : tmo ? HDR : REQ;
            WREL:    state_nxt = !writeport_ack ? (len_r == '0 ? FIN : DHI) : tmo ? HDR : WREL;
            default: state_nxt = HDR;
        endcase
        abort = (state == REQ || state == WREL) && state_nxt == HDR;
    end

    assign writeport_addr = addr_r >> 1;
    assign writeport_data = data_r;
    assign busy           = busy_r;
    assign error          = error_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= HDR;
            addr_r  <= '0;
            len_r   <= '0;
            data_r  <= '0;
            cnt     <= '0;
            busy_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= state_nxt != state ? '0 : cnt + CW'(1);
            if (hdr_first) begin
                busy_r  <= 1'b1;
                error_r <= 1'b0;
            end
            if (hdr_last) begin
                addr_r <= hdr_addr & 32'hFFFF_FFFE;
                len_r  <= hdr_len;
            end
            // The pad byte is preloaded with the hi byte; a following lo byte overwrites it.
            if (state == DHI && take) begin
                data_r <= {in_data, PAD_BYTE};
                len_r  <= len_r - 32'd1;
            end
            if (state == DLO && take) begin
                data_r[7:0] <= in_data;
                len_r       <= len_r - 32'd1;
            end
            if (state == WREL && !writeport_ack) addr_r <= addr_r + 32'd2;
            if (state_nxt == FIN || abort) busy_r <= 1'b0;
            if (abort) error_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_rom_loader.sv
// tb_sdram_rom_loader: randomized frames against a halfword-list model plus an ack-handshake scoreboard.
module tb_sdram_rom_loader;

    localparam int         T   = 64;
    localparam logic [7:0] PAD = 8'h00;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, ack = 1'b0, ack_en = 1'b1;
    logic        in_ready, wr, busy, done, error;
    logic [7:0]  in_data = 8'h00;
    logic [31:0] waddr;
    logic [15:0] wdata;

    int          n_cmp = 0, n_err = 0, done_cnt = 0, dly = 0;
    logic        wr_q = 1'b0, ack_q = 1'b0, done_q = 1'b0, hold = 1'b0;
    logic [47:0] held;
    logic [47:0] got[$], exp_q[$];
    logic [7:0]  fr[$];

    always #5 clk = ~clk;

    sdram_rom_loader #(.PAD_BYTE(PAD), .ACK_TIMEOUT(T)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .writeport_wr   (wr),
        .writeport_addr (waddr),
        .writeport_data (wdata),
        .writeport_ack  (ack),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    // SDRAM controller stand-in: random ack latency in both directions, never reset.
    always @(posedge clk) begin
        if (wr && !ack && ack_en) begin
            if (dly == 0) begin
                ack <= 1'b1;
                dly <= int'($urandom_range(0, 3));
            end else dly <= dly - 1;
        end else if (!wr && ack) begin
            if (dly == 0) begin
                ack <= 1'b0;
                dly <= int'($urandom_range(0, 3));
            end else dly <= dly - 1;
        end
    end

    task automatic cyc();
        @(negedge clk);
        if (wr && !wr_q) begin
            n_cmp++;
            if (ack_q !== 1'b0) begin
                n_err++;
                $display("FAIL wr_rise: ack=%b when wr rose, required 0", ack_q);
            end
            got.push_back({waddr, wdata});
            held = {waddr, wdata};
            hold = 1'b1;
        end else if (hold && (wr || ack)) begin
            n_cmp++;
            if ({waddr, wdata} !== held) begin
                n_err++;
                $display("FAIL hold_stable: addr/data=%h required %h", {waddr, wdata}, held);
            end
        end
        if (!wr && !ack) hold = 1'b0;
        if (done) begin
            done_cnt++;
            n_cmp++;
            if (done_q !== 1'b0) begin
                n_err++;
                $display("FAIL done_pulse: done high %0d cycles, required 1", 2);
            end
        end
        wr_q   = wr;
        ack_q  = ack;
        done_q = done;
    endtask

    task automatic send_bytes(input int lo, input int hi);
        int   n;
        logic ok;
        for (int i = lo; i < hi; i++) begin
            n = 0;
            if ($urandom_range(0, 3) == 0) cyc();
            in_valid = 1'b1;
            in_data  = fr[i];
            ok = in_ready;
            cyc();
            while (!ok && n < 4 * T) begin
                ok = in_ready;
                cyc();
                n++;
            end
            in_valid = 1'b0;
            if (!ok) begin
                n_cmp++;
                n_err++;
                $display("FAIL in_ready_wait: byte %0d not accepted within %0d cycles", i, 4 * T);
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 1000) begin
            cyc();
            n++;
        end
        if (done_cnt == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_wait: no done within 1000 cycles");
        end
    endtask

    function automatic void mk(input logic [31:0] a, input logic [31:0] len);
        fr.delete();
        for (int i = 0; i < 4; i++) fr.push_back(a[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) fr.push_back(len[31-8*i -: 8]);
        for (int i = 0; i < int'(len); i++) fr.push_back(8'($urandom));
        got.delete();
        done_cnt = 0;
    endfunction

    // Expected writes: one per byte pair, halfword address of the even byte, odd tail padded.
    function automatic void model(input logic [31:0] a, input int len);
        logic [31:0] ba;
        exp_q.delete();
        for (int i = 0; i < len; i += 2) begin
            ba = (a & 32'hFFFF_FFFE) + 32'(i);
            exp_q.push_back({1'b0, ba[31:1], fr[8+i], (i + 1 < len) ? fr[9+i] : PAD});
        end
    endfunction

    task automatic test_reset();
        #3 rst = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if ({in_ready, wr, busy, done, error} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: rdy/wr/busy/done/err=%b required 00000", {in_ready, wr, busy, done, error});
        end
        n_cmp++;
        if (waddr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_addr: %h required 0", waddr);
        end
        n_cmp++;
        if (wdata !== 16'h0) begin
            n_err++;
            $display("FAIL reset_data: %h required 0", wdata);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: %b required 1", in_ready);
        end
        cyc();
    endtask

    task automatic test_basic();
        mk(32'h0000_0100, 32'd4);
        fr[8] = 8'hAA; fr[9] = 8'hBB; fr[10] = 8'hCC; fr[11] = 8'hDD;
        send_bytes(0, 12);
        wait_done();
        n_cmp++;
        if (got.size() != 2) begin
            n_err++;
            $display("FAIL basic_count: %0d writes required 2", got.size());
        end else begin
            n_cmp++;
            if (got[0] !== {32'h80, 16'hAABB}) begin
                n_err++;
                $display("FAIL basic_w0: %h required %h", got[0], {32'h80, 16'hAABB});
            end
            n_cmp++;
            if (got[1] !== {32'h81, 16'hCCDD}) begin
                n_err++;
                $display("FAIL basic_w1: %h required %h", got[1], {32'h81, 16'hCCDD});
            end
        end
        n_cmp++;
        if ({error, busy, done_cnt == 1} !== 3'b001) begin
            n_err++;
            $display("FAIL basic_status: err=%b busy=%b dones=%0d required 0 0 1", error, busy, done_cnt);
        end
    endtask

    task automatic test_odd_len();
        mk(32'h0, 32'd3);
        fr[8] = 8'h11; fr[9] = 8'h22; fr[10] = 8'h33;
        send_bytes(0, 11);
        wait_done();
        n_cmp++;
        if (got.size() != 2) begin
            n_err++;
            $display("FAIL odd_count: %0d writes required 2", got.size());
        end else begin
            n_cmp++;
            if (got[0][15:0] !== 16'h1122 || got[1][15:0] !== 16'h3300) begin
                n_err++;
                $display("FAIL odd_data: %h %h required 1122 3300", got[0][15:0], got[1][15:0]);
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL odd_done: %0d pulses required 1", done_cnt);
        end
    endtask

    task automatic test_len0();
        mk($urandom, 32'd0);
        send_bytes(0, 8);
        n_cmp++;
        if ({done, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL len0_done: done=%b busy=%b required 1 0", done, busy);
        end
        cyc();
        n_cmp++;
        if (done !== 1'b0 || got.size() != 0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL len0_after: done=%b writes=%0d err=%b required 0 0 0", done, got.size(), error);
        end
    endtask

    task automatic test_odd_addr();
        mk(32'h0000_0101, 32'd2);
        send_bytes(0, 10);
        wait_done();
        n_cmp++;
        if (got.size() != 1) begin
            n_err++;
            $display("FAIL oddaddr_count: %0d writes required 1", got.size());
        end else begin
            n_cmp++;
            if (got[0][47:16] !== 32'h80) begin
                n_err++;
                $display("FAIL oddaddr_addr: %h required 00000080", got[0][47:16]);
            end
        end
    endtask

    task automatic test_timeout();
        int n, run;
        ack_en = 1'b0;
        mk(32'h0000_2000, 32'd2);
        send_bytes(0, 10);
        n = 0;
        while (!wr && n < 20) begin
            cyc();
            n++;
        end
        run = 0;
        while (wr && run < T + 20) begin
            run++;
            cyc();
        end
        n_cmp++;
        if (run != T) begin
            n_err++;
            $display("FAIL timeout_len: wr high %0d cycles required %0d", run, T);
        end
        n_cmp++;
        if ({error, busy, in_ready} !== 3'b101 || done_cnt != 0) begin
            n_err++;
            $display("FAIL timeout_status: err=%b busy=%b rdy=%b dones=%0d required 1 0 1 0", error, busy, in_ready, done_cnt);
        end
        ack_en = 1'b1;
        mk(32'h0000_3000, 32'd2);
        model(32'h0000_3000, 2);
        send_bytes(0, 1);
        n_cmp++;
        if ({error, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL timeout_clear: err=%b busy=%b required 0 1", error, busy);
        end
        send_bytes(1, 10);
        wait_done();
        n_cmp++;
        if (got.size() != exp_q.size() || got[0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL timeout_resend: %0d writes first %h required 1 writes %h", got.size(), got.size() > 0 ? got[0] : 48'h0, exp_q[0]);
        end
    endtask

    task automatic test_reset_req();
        logic [31:0] a;
        ack_en = 1'b0;
        mk(32'h0000_4000, 32'd4);
        send_bytes(0, 10);
        cyc();
        cyc();
        n_cmp++;
        if (wr !== 1'b1) begin
            n_err++;
            $display("FAIL rreq_pre: wr=%b required 1", wr);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({wr, busy, in_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL rreq_async: wr/busy/rdy=%b required 000", {wr, busy, in_ready});
        end
        cyc();
        rst = 1'b1;
        ack_en = 1'b1;
        cyc();
        a = $urandom;
        mk(a, 32'd5);
        model(a, 5);
        send_bytes(0, 13);
        wait_done();
        n_cmp++;
        if (got.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rreq_count: %0d writes required %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rreq_w%0d: %h required %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        int          len;
        for (int f = 0; f < 8; f++) begin
            a   = f == 0 ? 32'hFFFF_FFFC : $urandom;
            len = f == 0 ? 8 : int'($urandom_range(0, 9));
            mk(a, 32'(len));
            model(a, len);
            send_bytes(0, fr.size());
            wait_done();
            n_cmp++;
            if (got.size() != exp_q.size() || done_cnt != 1 || error !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_frame%0d: writes=%0d dones=%0d err=%b required %0d 1 0", f, got.size(), done_cnt, error, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                n_cmp++;
                if (got[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL b2b_frame%0d_w%0d: %h required %h", f, i, got[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd_len();
        test_len0();
        test_odd_addr();
        test_timeout();
        test_reset_req();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
